// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame constants,
// common to uart_rx and uart_tx.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset
// value is a parameter so an idle-high line reads as idle out of reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit with a clock-cycle counter,
// emits a one-cycle data_valid or frame_err pulse per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIDX_LAST = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  logic [2:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bidx_q, bidx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]                data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Half-bit check rejects glitches and aligns later samples to bit centres
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          bidx_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
          bidx_d  = bidx_q + 3'd1;
          if (bidx_q == BIDX_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk per bit: normal, back-to-back, glitch,
// framing error, mid-frame reset and bit-rate tolerance cases.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned ferr_cnt = 0;
  int unsigned both_cnt = 0;
  logic [7:0]  vdata[$];
  int unsigned vcyc[$];

  uart_rx #(.CLKS_PER_BIT(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      vdata.push_back(data_out);
      vcyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (data_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called and returns #1 after a rising edge; the start bit begins at that edge.
  task automatic send_frame(input logic [7:0] d, input int unsigned per, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (per) @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic level, input int unsigned n);
    rx = level;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int unsigned n0;
  int unsigned e0;
  int unsigned f0;
  int unsigned f1;

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    hold(1'b1, 10);

    // Single frame and latency from the pin falling edge
    n0 = vdata.size();
    send_frame(8'hA5, 16, 1'b1);
    f0 = fall_cyc;
    hold(1'b1, 20);
    check("a5_count", 32'(vdata.size()), 32'(n0 + 1));
    if (vdata.size() > n0) begin
      check("a5_data", 32'(vdata[n0]), 32'hA5);
      check("a5_latency", vcyc[n0] - f0, 32'd155);
    end
    check("a5_no_ferr", ferr_cnt, 32'd0);

    // Back-to-back with no idle gap
    n0 = vdata.size();
    send_frame(8'h00, 16, 1'b1);
    f0 = fall_cyc;
    send_frame(8'hFF, 16, 1'b1);
    f1 = fall_cyc;
    hold(1'b1, 20);
    check("b2b_count", 32'(vdata.size()), 32'(n0 + 2));
    check("b2b_frame_gap", f1 - f0, 32'd160);
    if (vdata.size() >= n0 + 2) begin
      check("b2b_first", 32'(vdata[n0]), 32'h00);
      check("b2b_second", 32'(vdata[n0 + 1]), 32'hFF);
      check("b2b_spacing", vcyc[n0 + 1] - vcyc[n0], 32'd160);
    end

    // Short low glitch must not produce a frame
    n0 = vdata.size();
    hold(1'b0, 5);
    hold(1'b1, 30);
    check("glitch_no_pulse", 32'(vdata.size()), 32'(n0));
    check("glitch_busy", 32'(busy), 32'd0);
    send_frame(8'h3C, 16, 1'b1);
    hold(1'b1, 20);
    check("post_glitch_count", 32'(vdata.size()), 32'(n0 + 1));
    check("post_glitch_data", 32'(data_out), 32'h3C);

    // Stop bit low, line then held low: one frame_err, wait for high
    n0 = vdata.size();
    e0 = ferr_cnt;
    send_frame(8'h55, 16, 1'b0);
    hold(1'b0, 40);
    check("ferr_pulse", ferr_cnt, e0 + 1);
    check("ferr_no_valid", 32'(vdata.size()), 32'(n0));
    check("ferr_data_kept", 32'(data_out), 32'h3C);
    check("ferr_busy_low_line", 32'(busy), 32'd1);
    hold(1'b1, 20);
    check("ferr_busy_released", 32'(busy), 32'd0);
    send_frame(8'h12, 16, 1'b1);
    hold(1'b1, 20);
    check("post_ferr_count", 32'(vdata.size()), 32'(n0 + 1));
    check("post_ferr_data", 32'(data_out), 32'h12);
    check("post_ferr_no_extra", ferr_cnt, e0 + 1);

    // Reset in the middle of data bit 3 of an 8'hF0 frame
    n0 = vdata.size();
    hold(1'b0, 16);
    hold(1'b0, 48);
    hold(1'b0, 8);
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    hold(1'b0, 8);
    hold(1'b1, 16);
    hold(1'b1, 8);
    rst_n = 1'b1;
    hold(1'b1, 8);
    hold(1'b1, 48);
    hold(1'b1, 200);
    check("midrst_no_pulse", 32'(vdata.size()), 32'(n0));
    send_frame(8'h81, 16, 1'b1);
    hold(1'b1, 20);
    check("post_rst_count", 32'(vdata.size()), 32'(n0 + 1));
    check("post_rst_data", 32'(data_out), 32'h81);

    // Transmitter bit period off by one clock either way
    n0 = vdata.size();
    send_frame(8'hC3, 15, 1'b1);
    hold(1'b1, 40);
    check("tol15_data", 32'(data_out), 32'hC3);
    check("tol15_count", 32'(vdata.size()), 32'(n0 + 1));
    hold(1'b0, 1);
    hold(1'b1, 40);
    n0 = vdata.size();
    send_frame(8'hC3, 17, 1'b1);
    hold(1'b1, 40);
    check("tol17_data", 32'(data_out), 32'hC3);
    check("tol17_count", 32'(vdata.size()), 32'(n0 + 1));

    check("valid_ferr_overlap", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
